// File: rtl/rvvi_pkg.sv
// Shared types and constants for the RVVI retransmit path.
// No logic; latency n/a.
// Backpressure n/a.
package rvvi_pkg;

    typedef enum logic [1:0] {
        RL_IDLE,
        RL_REPLAY,
        RL_WAIT
    } rl_state_t;

    localparam int RVVI_TAG_LSB  = 160;
    localparam int RVVI_TAG_BITS = 16;

endpackage

// File: rtl/rvvi_tag_cam.sv
// Tag store with a parallel compare of the ack tag against every active entry.
// Write lands at the clock edge; hit/hit_idx are combinational from stored tags.
// No backpressure; at most one active entry is assumed to match.
module rvvi_tag_cam #(
    parameter int ENTRY_BITS = 3,
    parameter int TAG_BITS   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ENTRY_BITS-1:0]      wr_idx,
    input  logic [TAG_BITS-1:0]        wr_tag,
    input  logic [2**ENTRY_BITS-1:0]   active,
    input  logic [TAG_BITS-1:0]        match_tag,
    output logic                       hit,
    output logic [ENTRY_BITS-1:0]      hit_idx
);

    localparam int N = 2**ENTRY_BITS;

    logic [TAG_BITS-1:0] tags [N];
    logic [N-1:0]        match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) tags[i] <= '0;
        end else if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    // OR-reduction encoder is exact because matches are one-hot.
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = active[i] && (tags[i] == match_tag);
            if (match[i]) hit_idx = hit_idx | ENTRY_BITS'(i);
        end
        hit = |match;
    end

endmodule

// File: rtl/rvvi_replay_list.sv
// RVVI retransmit buffer: holds sent packets until acked, replays unacked ones on gap/timeout.
// Insert and ack take effect at the next edge; replay beats are combinational from the store.
// Replay beats obey RplValid/RplReady and hold stable until accepted; inserts dropped when Full.
module rvvi_replay_list
    import rvvi_pkg::*;
#(
    parameter int ENTRY_BITS = 3,
    parameter int WIDTH      = 792,
    parameter int TAG_BITS   = RVVI_TAG_BITS,
    parameter int TAG_LSB    = RVVI_TAG_LSB,
    parameter int TIMER_BITS = 16,
    parameter int RETRY_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    InsValid,
    input  logic [WIDTH-1:0]        InsData,
    output logic                    InsReady,
    input  logic                    AckValid,
    input  logic [TAG_BITS-1:0]     AckTag,
    input  logic [TIMER_BITS-1:0]   TimeoutCyc,
    output logic                    RplValid,
    output logic [WIDTH-1:0]        RplData,
    input  logic                    RplReady,
    output logic                    Full,
    output logic                    Empty,
    output logic [ENTRY_BITS:0]     Count,
    output logic                    Busy,
    output logic                    Overflow,
    output logic                    AckMiss,
    output logic                    ReplayFail
);

    localparam int                    N         = 2**ENTRY_BITS;
    localparam logic [ENTRY_BITS:0]   PTR_SPAN  = {1'b1, {ENTRY_BITS{1'b0}}};
    localparam logic [RETRY_BITS-1:0] MAX_RETRY = '1;

    logic [WIDTH-1:0]       mem [N];
    logic [N-1:0]           active;
    logic [N-1:0]           ack_clr;
    logic [N-1:0]           ins_set;
    logic [ENTRY_BITS:0]    head, tail, scan_ptr, end_ptr;
    logic [ENTRY_BITS:0]    scan_nxt, end_nxt, win_left;
    logic [TIMER_BITS-1:0]  timer;
    logic [RETRY_BITS-1:0]  retries, retries_nxt;
    rl_state_t              state, state_nxt;
    logic                   beat_hold;
    logic                   ins_ok, retire, timeout, gap, ack_hit, fail_set;
    logic                   enter_replay, window_done, cam_hit;
    logic [ENTRY_BITS-1:0]  cam_idx, head_idx, tail_idx, scan_idx;

    assign head_idx = head[ENTRY_BITS-1:0];
    assign tail_idx = tail[ENTRY_BITS-1:0];
    assign scan_idx = scan_ptr[ENTRY_BITS-1:0];

    assign Full     = (head ^ tail) == PTR_SPAN;
    assign Empty    = head == tail;
    assign Count    = head - tail;
    assign InsReady = ~Full;
    assign Busy     = state != RL_IDLE;

    assign ins_ok  = InsValid & ~Full;
    assign ack_hit = AckValid & cam_hit;
    assign retire  = ~Empty & ~active[tail_idx];
    assign timeout = (TimeoutCyc != '0) && (timer == TimeoutCyc);
    assign gap     = ack_hit && (cam_idx != tail_idx);

    assign ins_set = ins_ok  ? (N'(1) << head_idx) : '0;
    assign ack_clr = ack_hit ? (N'(1) << cam_idx)  : '0;

    // Tail may run past EndPtr while a beat is stalled; a wrapped distance means it already did.
    assign win_left    = end_ptr - tail;
    assign window_done = (win_left == '0) || (win_left > PTR_SPAN);

    assign enter_replay = (state_nxt == RL_REPLAY) && (state != RL_REPLAY);
    assign RplData      = RplValid ? mem[scan_idx] : '0;

    rvvi_tag_cam #(
        .ENTRY_BITS (ENTRY_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_cam (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (ins_ok),
        .wr_idx    (head_idx),
        .wr_tag    (InsData[TAG_LSB +: TAG_BITS]),
        .active    (active),
        .match_tag (AckTag),
        .hit       (cam_hit),
        .hit_idx   (cam_idx)
    );

    always_comb begin
        state_nxt   = state;
        scan_nxt    = scan_ptr;
        end_nxt     = end_ptr;
        retries_nxt = retries;
        fail_set    = 1'b0;
        RplValid    = 1'b0;
        case (state)
            RL_IDLE: begin
                if (gap || timeout) begin
                    state_nxt   = RL_REPLAY;
                    scan_nxt    = tail;
                    end_nxt     = head;
                    retries_nxt = '0;
                end
            end
            RL_REPLAY: begin
                if (scan_ptr == end_ptr) begin
                    state_nxt = RL_WAIT;
                end else if (active[scan_idx] || beat_hold) begin
                    RplValid = 1'b1;
                    if (RplReady) scan_nxt = scan_ptr + 1'b1;
                end else begin
                    scan_nxt = scan_ptr + 1'b1;
                end
            end
            RL_WAIT: begin
                if (window_done) begin
                    state_nxt = RL_IDLE;
                end else if (timeout) begin
                    if (retries == MAX_RETRY) begin
                        fail_set  = 1'b1;
                        state_nxt = RL_IDLE;
                    end else begin
                        retries_nxt = retries + 1'b1;
                        scan_nxt    = tail;
                        end_nxt     = head;
                        state_nxt   = RL_REPLAY;
                    end
                end
            end
            default: state_nxt = RL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RL_IDLE;
            head       <= '0;
            tail       <= '0;
            scan_ptr   <= '0;
            end_ptr    <= '0;
            active     <= '0;
            timer      <= '0;
            retries    <= '0;
            beat_hold  <= 1'b0;
            Overflow   <= 1'b0;
            AckMiss    <= 1'b0;
            ReplayFail <= 1'b0;
        end else begin
            state     <= state_nxt;
            scan_ptr  <= scan_nxt;
            end_ptr   <= end_nxt;
            retries   <= retries_nxt;
            beat_hold <= RplValid & ~RplReady;
            active    <= (active & ~ack_clr) | ins_set;
            if (ins_ok) head <= head + 1'b1;
            if (retire) tail <= tail + 1'b1;
            if (retire || enter_replay) timer <= '0;
            else if (!Empty)            timer <= timer + 1'b1;
            if (InsValid && Full)       Overflow   <= 1'b1;
            if (AckValid && !cam_hit)   AckMiss    <= 1'b1;
            if (fail_set)               ReplayFail <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_ok) mem[head_idx] <= InsData;
    end

endmodule
